// File: rtl/barrett_share_arb.sv
// barrett_share_arb: round-robin share of a 2-stage Barrett reducer with a tag pipeline; BARRETT_ARB_CHECK_EN adds a sticky range check
module barrett_share_arb #(
    parameter int WIDTH   = 16,
    parameter int NREQ    = 4,
    parameter int RED_LAT = 2,
    parameter int QMOD    = 3329
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NREQ-1:0]               req_valid_i,
    input  logic [NREQ*2*WIDTH-1:0]       req_data_i,
    output logic [NREQ-1:0]               req_ready_o,
    input  logic [NREQ-1:0]               cfg_mask_i,
    output logic [2*WIDTH-1:0]            red_c_o,
    input  logic [12:0]                   red_r_i,
    output logic [NREQ-1:0]               rsp_valid_o,
    output logic [12:0]                   rsp_data_o,
    output logic [$clog2(NREQ)-1:0]       rsp_id_o,
    output logic [$clog2(RED_LAT+2)-1:0]  inflight_o,
    output logic                          chk_err_o
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(RED_LAT+2);
    localparam int DW = 2*WIDTH;
    localparam int TW = RED_LAT*IW;

    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v % NREQ);
    endfunction

    logic [NREQ-1:0]              w_elig;
    logic                         w_found;
    logic [IW-1:0]                w_gid;
    logic                         w_last;
    logic [IW-1:0]                r_ptr;
    logic [RED_LAT-1:0]           r_tv;
    logic [RED_LAT-1:0][IW-1:0]   r_tid;
    logic [NREQ-1:0]              r_rsp_valid;
    logic [12:0]                  r_rsp_data;
    logic [IW-1:0]                r_rsp_id;
    logic [CW-1:0]                r_inflight;

    assign w_elig = req_valid_i & cfg_mask_i;

    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && w_elig[wrap(int'(r_ptr) + i)]) begin
                w_found = 1'b1;
                w_gid   = wrap(int'(r_ptr) + i);
            end
        end
    end

    assign req_ready_o = w_found ? NREQ'(1) << w_gid : '0;
    assign red_c_o     = w_found ? req_data_i[w_gid*DW +: DW] : '0;
    assign w_last      = r_tv[RED_LAT-1];

    // The reducer carries no valid, so {valid,id} travels alongside it for RED_LAT clocks
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr       <= '0;
            r_tv        <= '0;
            r_tid       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_inflight  <= '0;
        end else begin
            r_ptr       <= w_found ? wrap(int'(w_gid) + 1) : r_ptr;
            r_tv        <= (r_tv << 1) | RED_LAT'(w_found);
            r_tid       <= (r_tid << IW) | TW'(w_gid);
            r_rsp_valid <= w_last ? NREQ'(1) << r_tid[RED_LAT-1] : '0;
            r_rsp_data  <= w_last ? red_r_i : r_rsp_data;
            r_rsp_id    <= w_last ? r_tid[RED_LAT-1] : r_rsp_id;
            r_inflight  <= r_inflight + CW'(w_found) - CW'(|r_rsp_valid);
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_id_o    = r_rsp_id;
    assign inflight_o  = r_inflight;

`ifdef BARRETT_ARB_CHECK_EN
    logic r_chk;
    logic w_bad;

    assign w_bad = w_last && (red_r_i >= 13'(QMOD));

    always_ff @(posedge clk_i) begin
        if (rst_i) r_chk <= 1'b0;
        else r_chk <= r_chk | w_bad;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && w_bad) $error("barrett_share_arb: id %0d result %0d out of range", r_tid[RED_LAT-1], red_r_i);
    end

    assign chk_err_o = r_chk;
`else
    assign chk_err_o = 1'b0;
`endif
endmodule
